// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI definitions: frame state encoding and default word width
package spi_pkg;

  localparam int SPI_WORD_WIDTH = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } spi_state_t;

endpackage

// File: rtl/spi_sclk_div.sv
// rtl/spi_sclk_div.sv - SCLK timebase: one-cycle tick every CLK_DIV cycles while enabled
module spi_sclk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Held at zero while disabled so every frame starts on a full half-period.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
    end else if (!en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - Mode-0 SPI master, MSB first; SPI_MASTER_BURST_EN keeps CS_N low across back-to-back words
module spi_master
  import spi_pkg::*;
#(
  parameter int WORD_WIDTH = SPI_WORD_WIDTH,
  parameter int CLK_DIV    = 4,
  parameter int CS_GAP     = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [WORD_WIDTH-1:0] DIN,
  input  logic                  DIN_VLD,
  output logic                  DIN_RDY,
  output logic [WORD_WIDTH-1:0] DOUT,
  output logic                  DOUT_VLD,
  output logic                  SCLK,
  output logic                  CS_N,
  output logic                  MOSI,
  input  logic                  MISO
);

  localparam int BW = $clog2(WORD_WIDTH + 1);
  localparam int GW = $clog2(CS_GAP + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_WIDTH);
  localparam logic [GW-1:0] LAST_GAP = GW'(CS_GAP - 1);

  spi_state_t            state;
  logic [WORD_WIDTH-1:0] tx_sr;
  logic [WORD_WIDTH-1:0] rx_sr;
  logic [BW-1:0]         bit_cnt;
  logic [GW-1:0]         gap_cnt;
  logic                  rdy_q;
  logic                  div_en;
  logic                  tick;
  logic                  hold_done;
  logic                  accept;

  assign div_en = (state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_HOLD);

  spi_sclk_div #(.CLK_DIV(CLK_DIV)) u_sclk_div (
    .CLK  (CLK),
    .RST_N(RST_N),
    .en   (div_en),
    .tick (tick)
  );

  assign hold_done = (state == ST_HOLD) && tick;

`ifdef SPI_MASTER_BURST_EN
  assign DIN_RDY = rdy_q | hold_done;
`else
  assign DIN_RDY = rdy_q;
`endif

  assign accept = DIN_VLD && DIN_RDY;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      tx_sr    <= '0;
      rx_sr    <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      rdy_q    <= 1'b0;
      SCLK     <= 1'b0;
      CS_N     <= 1'b1;
      MOSI     <= 1'b0;
      DOUT     <= '0;
      DOUT_VLD <= 1'b0;
    end else begin
      DOUT_VLD <= 1'b0;
      if (accept) begin
        // A burst accept also retires the word that just finished HOLD.
        state   <= ST_SETUP;
        tx_sr   <= DIN;
        MOSI    <= DIN[WORD_WIDTH-1];
        CS_N    <= 1'b0;
        rdy_q   <= 1'b0;
        bit_cnt <= '0;
        if (hold_done) begin
          DOUT     <= rx_sr;
          DOUT_VLD <= 1'b1;
        end
      end else begin
        case (state)
          ST_IDLE: rdy_q <= 1'b1;
          ST_SETUP: begin
            if (tick) begin
              state   <= ST_SHIFT;
              SCLK    <= 1'b1;
              rx_sr   <= {rx_sr[WORD_WIDTH-2:0], MISO};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          ST_SHIFT: begin
            if (tick) begin
              if (SCLK) begin
                SCLK <= 1'b0;
                if (bit_cnt != LAST_BIT) begin
                  tx_sr <= tx_sr << 1;
                  MOSI  <= tx_sr[WORD_WIDTH-2];
                end
              end else if (bit_cnt == LAST_BIT) begin
                state <= ST_HOLD;
              end else begin
                SCLK    <= 1'b1;
                rx_sr   <= {rx_sr[WORD_WIDTH-2:0], MISO};
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          ST_HOLD: begin
            if (tick) begin
              state    <= ST_GAP;
              CS_N     <= 1'b1;
              DOUT     <= rx_sr;
              DOUT_VLD <= 1'b1;
              gap_cnt  <= '0;
            end
          end
          ST_GAP: begin
            // Ready is raised as IDLE is entered so the first IDLE cycle can accept.
            if (gap_cnt == LAST_GAP) begin
              state <= ST_IDLE;
              rdy_q <= 1'b1;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - scoreboard bench for spi_master with a behavioural SPI slave model
module tb_spi_master;

  localparam int W     = 64;
  localparam int D     = 4;
  localparam int G     = 8;
  localparam int FRAME = (2 * W + 2) * D;
`ifdef SPI_MASTER_BURST_EN
  localparam int MIN_SP = FRAME;
`else
  localparam int MIN_SP = FRAME + G + 1;
`endif

  typedef struct {
    logic [W-1:0] din;
    logic [W-1:0] dout;
  } exp_t;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b1;
  logic [W-1:0] DIN = '0;
  logic         DIN_VLD = 1'b0;
  logic         DIN_RDY;
  logic [W-1:0] DOUT;
  logic         DOUT_VLD;
  logic         SCLK;
  logic         CS_N;
  logic         MOSI;
  logic         MISO;

  logic [7:0]   din2 = '0;
  logic         vld2 = 1'b0;
  logic         rdy2;
  logic [7:0]   dout2;
  logic         dvld2;
  logic         sclk2;
  logic         csn2;
  logic         mosi2;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t         exp_q[$];
  logic [W-1:0] slave_q[$];
  logic [W-1:0] slave_sr = '0;
  logic [W-1:0] mosi_acc = '0;
  logic [W-1:0] last_dout = '0;
  bit           loopback = 1'b0;
  bit           hold_mode = 1'b0;
  bit           last_hold = 1'b0;
  bit           have_acc = 1'b0;
  bit           have_done = 1'b0;
  bit           acc_pend = 1'b0;
  bit           prev_sclk = 1'b0;
  bit           prev_vld = 1'b0;
  int           cyc = 0;
  int           frame_start = 0;
  int           rises = 0;
  int           gapc = 0;
  int           cs_high_cnt = 0;

  spi_master dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .DIN     (DIN),
    .DIN_VLD (DIN_VLD),
    .DIN_RDY (DIN_RDY),
    .DOUT    (DOUT),
    .DOUT_VLD(DOUT_VLD),
    .SCLK    (SCLK),
    .CS_N    (CS_N),
    .MOSI    (MOSI),
    .MISO    (MISO)
  );

  spi_master #(.WORD_WIDTH(8), .CLK_DIV(2), .CS_GAP(8)) dut_small (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .DIN     (din2),
    .DIN_VLD (vld2),
    .DIN_RDY (rdy2),
    .DOUT    (dout2),
    .DOUT_VLD(dvld2),
    .SCLK    (sclk2),
    .CS_N    (csn2),
    .MOSI    (mosi2),
    .MISO    (mosi2)
  );

  // Slave model: shifts its word out MSB first, advancing after each SCLK rise.
  assign MISO = loopback ? MOSI : slave_sr[W-1];

  always #5 CLK = ~CLK;

  task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    check(name, act === exp, act, exp);
  endtask

  // Monitor: pops the scoreboard on every DOUT_VLD and checks frame shape.
  always @(negedge CLK) begin
    exp_t         e;
    logic [W-1:0] nd;
    cyc++;
    if (!RST_N) begin
      have_acc  = 1'b0;
      have_done = 1'b0;
      acc_pend  = 1'b0;
      prev_sclk = 1'b0;
      prev_vld  = 1'b0;
      gapc      = 0;
      last_dout = '0;
    end else begin
      if (DOUT_VLD) begin
        check("dout_vld_one_cycle", !prev_vld, 64'(prev_vld), 64'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_dout_vld", 1'b0, DOUT, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("dout", DOUT, e.dout);
          check_eq("mosi_stream", mosi_acc, e.din);
          check_eq("sclk_rises", 64'(rises), 64'(W));
          check_eq("cs_low_cycles", 64'(cyc - frame_start), 64'(FRAME));
`ifndef SPI_MASTER_BURST_EN
          check_eq("cs_n_at_dout_vld", 64'(CS_N), 64'd1);
`endif
          last_dout = e.dout;
        end
        have_done = 1'b1;
        gapc      = 0;
      end
      if (CS_N) cs_high_cnt++;
      if (CS_N && !DIN_RDY) gapc++;
      if (acc_pend) begin
        if (have_acc) begin
          if (hold_mode && last_hold)
            check_eq("accept_spacing", 64'(cyc - frame_start), 64'(MIN_SP));
          else
            check("accept_spacing_min", (cyc - frame_start) >= MIN_SP, 64'(cyc - frame_start), 64'(MIN_SP));
        end
`ifndef SPI_MASTER_BURST_EN
        if (have_done) check_eq("cs_gap_cycles", 64'(gapc), 64'(G));
`endif
        have_done = 1'b0;
        check_eq("cs_n_after_accept", 64'(CS_N), 64'd0);
        if (exp_q.size() > 0) begin
          nd = exp_q[$].din;
          check_eq("mosi_first_bit", 64'(MOSI), 64'(nd[W-1]));
        end
        check_eq("dout_held", DOUT, last_dout);
        frame_start = cyc;
        have_acc    = 1'b1;
        last_hold   = hold_mode;
        mosi_acc    = '0;
        rises       = 0;
        if (slave_q.size() > 0) slave_sr = slave_q.pop_front();
        else slave_sr = '0;
      end
      if (SCLK && !prev_sclk) begin
        mosi_acc = {mosi_acc[W-2:0], MOSI};
        rises++;
        slave_sr = slave_sr << 1;
      end
      acc_pend  = DIN_VLD && DIN_RDY;
      prev_sclk = SCLK;
      prev_vld  = DOUT_VLD;
    end
  end

  task automatic send(input logic [W-1:0] d, input logic [W-1:0] sw, input int idle);
    exp_t e;
    bit   ok;
    if (idle > 0) begin
      repeat (idle) @(posedge CLK);
      #1;
    end
    DIN     = d;
    DIN_VLD = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge CLK);
      if (DIN_RDY) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept_timeout", ok, 64'(ok), 64'd1);
    if (ok) begin
      e.din  = d;
      e.dout = loopback ? d : sw;
      exp_q.push_back(e);
      slave_q.push_back(sw);
    end
    @(posedge CLK);
    #1;
    DIN     = {$urandom, $urandom};
    DIN_VLD = hold_mode;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge CLK);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("frame_timeout", ok, 64'(exp_q.size()), 64'd0);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   c0, c1, lowc, r2, bad_per, last_r, hi2;
    bit   ok, p2;
    logic [7:0] bits2;

    #2 RST_N = 1'b0;
    #1;
    check_eq("rst_cs_n", 64'(CS_N), 64'd1);
    check_eq("rst_sclk", 64'(SCLK), 64'd0);
    check_eq("rst_mosi", 64'(MOSI), 64'd0);
    check_eq("rst_din_rdy", 64'(DIN_RDY), 64'd0);
    check_eq("rst_dout", DOUT, 64'd0);
    check_eq("rst_dout_vld", 64'(DOUT_VLD), 64'd0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    #1 check_eq("rdy_low_until_edge", 64'(DIN_RDY), 64'd0);
    @(negedge CLK);
    check_eq("rdy_after_first_edge", 64'(DIN_RDY), 64'd1);
    @(posedge CLK);
    #1;

    loopback = 1'b1;
    send(64'h0100000000000022, '0, 0);
    wait_idle();
    loopback = 1'b0;
    send('0, '1, 0);
    wait_idle();

    hold_mode = 1'b1;
    send(64'hA5A5A5A5A5A5A5A5, {$urandom, $urandom}, 0);
    c0 = cs_high_cnt;
    send(64'h5A5A5A5A5A5A5A5A, {$urandom, $urandom}, 0);
    send({$urandom, $urandom}, {$urandom, $urandom}, 0);
    c1 = cs_high_cnt;
    DIN_VLD = 1'b0;
    wait_idle();
    hold_mode = 1'b0;
`ifdef SPI_MASTER_BURST_EN
    check_eq("cs_high_in_burst", 64'(c1 - c0), 64'd0);
`else
    check_eq("cs_high_between_held_words", 64'(c1 - c0), 64'(2 * (G + 1)));
`endif

    send({$urandom, $urandom}, {$urandom, $urandom}, 3);
    ok = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge CLK);
      if (rises >= 30) begin
        ok = 1'b1;
        break;
      end
    end
    check("reach_sclk_edge_30", ok, 64'(rises), 64'd30);
    #1 RST_N = 1'b0;
    #1;
    check_eq("abort_cs_n", 64'(CS_N), 64'd1);
    check_eq("abort_sclk", 64'(SCLK), 64'd0);
    check_eq("abort_din_rdy", 64'(DIN_RDY), 64'd0);
    check_eq("abort_dout_vld", 64'(DOUT_VLD), 64'd0);
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    send({$urandom, $urandom}, {$urandom, $urandom}, 1);
    wait_idle();

    for (int i = 0; i < 6; i++) begin
      loopback = ($urandom_range(0, 1) == 1);
      send({$urandom, $urandom}, {$urandom, $urandom}, int'($urandom_range(0, 20)));
      wait_idle();
    end
    loopback = 1'b0;

    din2 = 8'hC3;
    vld2 = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge CLK);
      if (rdy2) begin
        ok = 1'b1;
        break;
      end
    end
    check("small_accept", ok, 64'(ok), 64'd1);
    @(posedge CLK);
    #1 vld2 = 1'b0;
    lowc = 0; r2 = 0; bad_per = 0; last_r = 0; hi2 = 0; p2 = 1'b0; bits2 = '0; ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge CLK);
      if (!csn2) lowc++;
      if (sclk2) hi2++;
      if (sclk2 && !p2) begin
        bits2 = {bits2[6:0], mosi2};
        if (r2 > 0 && (n - last_r) != 4) bad_per++;
        last_r = n;
        r2++;
      end
      p2 = sclk2;
      if (dvld2) begin
        ok = 1'b1;
        break;
      end
    end
    check("small_done", ok, 64'(ok), 64'd1);
    check_eq("small_rises", 64'(r2), 64'd8);
    check_eq("small_mosi", 64'(bits2), 64'hC3);
    check_eq("small_period_bad", 64'(bad_per), 64'd0);
    check_eq("small_sclk_high", 64'(hi2), 64'd16);
    check_eq("small_cs_low", 64'(lowc), 64'd36);
    check_eq("small_dout", 64'(dout2), 64'hC3);

    check_eq("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master.md
# spi_master

Mode-0 SPI master that serialises one WORD_WIDTH-bit word per frame on MOSI, MSB first, while capturing MISO into a parallel word. It is the initiating end of the link served by `spi_slave`, which uses the same DIN/DOUT word-handshake style. It drives SCLK/CS_N from the system clock through a programmable divider. Use it as the FPGA-side host for bench loop-back, and on boards where the FPGA must initiate SPI transfers.

## Interface
- WORD_WIDTH, 64: bits per frame.
- CLK_DIV, 4: SCLK half-period in CLK cycles; legal values ≥ 2.
- CS_GAP, 8: CLK cycles with CS_N high between frames; legal values ≥ 1.
- CLK  in  1  system clock; all logic on its rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- DIN  in  WORD_WIDTH  word to transmit.
- DIN_VLD  in  1  DIN valid.
- DIN_RDY  out  1  master can accept a word; transfer occurs on a CLK edge where DIN_VLD && DIN_RDY.
- DOUT  out  WORD_WIDTH  last received word; holds its value until the next DOUT_VLD.
- DOUT_VLD  out  1  one-cycle pulse when DOUT is updated.
- SCLK  out  1  SPI clock; idles low.
- CS_N  out  1  chip select, active low.
- MOSI  out  1  serial data out.
- MISO  in  1  serial data in.

## Operation
- States:
  - IDLE: DIN_RDY=1.
  - SETUP: CS_N=0, MOSI=DIN[MSB], CLK_DIV cycles.
  - SHIFT: 2·WORD_WIDTH SCLK toggles, CLK_DIV cycles apart.
  - HOLD: SCLK=0, CS_N=0, CLK_DIV cycles.
  - GAP: CS_N=1, CS_GAP cycles.
- On accept in IDLE: latch DIN into the TX shift register, go to SETUP.
- SHIFT:
  - Rising SCLK: sample MISO into the RX shift register (LSB in, shift left).
  - Falling SCLK: present the next TX bit on MOSI.
  - No MOSI update after the final falling edge.
- End of HOLD: CS_N=1, DOUT ← RX register, DOUT_VLD=1 for one cycle, go to GAP.
- End of GAP: go to IDLE.
- Counters:
  - Divider counter: $clog2(CLK_DIV) bits, wraps CLK_DIV-1→0.
  - Bit counter: $clog2(WORD_WIDTH+1) bits, counts rising edges 0..WORD_WIDTH.
- Reset (asynchronous, may occur mid-frame):
  - Abort immediately to IDLE; no DOUT_VLD for the aborted frame.
  - Output values in reset: CS_N=1, SCLK=0, MOSI=0, DIN_RDY=0, DOUT=0, DOUT_VLD=0.
  - DIN_RDY rises on the first CLK edge after RST_N deasserts.
- DIN and DIN_VLD are ignored outside an accepting cycle. DIN may change once accepted.
- MISO is sampled directly; it is not synchronised.

## Timing
- Accept edge → CS_N low and MOSI=DIN[MSB] on the same edge's outputs (1-cycle latency).
- First SCLK rise occurs CLK_DIV cycles after CS_N falls.
- CS_N low duration: (2·WORD_WIDTH+2)·CLK_DIV cycles (520 at defaults).
- DOUT_VLD is asserted on the same edge that CS_N rises.
- Accept-to-accept minimum: (2·WORD_WIDTH+2)·CLK_DIV + CS_GAP + 1 cycles (529 at defaults, non-burst).
- SCLK duty is exactly 50%. Period = 2·CLK_DIV cycles.

## Configuration
- SPI_MASTER_BURST_EN defined:
  - DIN_RDY is also high during the final HOLD cycle.
  - Accept there: CS_N stays low, DOUT_VLD pulses for the finished word, MOSI=new DIN[MSB], next state SETUP; GAP is skipped.
  - Consecutive words share one CS_N-low window.
- Undefined: DIN_RDY only in IDLE; CS_N always returns high for CS_GAP between words.

## Structure
- Package spi_pkg holds:
  - State encoding (IDLE, SETUP, SHIFT, HOLD, GAP).
  - Default WORD_WIDTH, shared with spi_slave.
- Sub-module spi_sclk_div: free-running only while enabled. Emits a one-cycle `tick` every CLK_DIV cycles; `tick` drives SCLK toggling and state timing.

## Test plan
- Reset, then DIN=64'h0100000000000022 with MISO looped to MOSI → MOSI bit stream 0x0100000000000022 MSB first; DOUT=64'h0100000000000022; DOUT_VLD one cycle; CS_N low 520 cycles.
- MISO tied 1, DIN=0 → DOUT=64'hFFFFFFFFFFFFFFFF; MOSI constant 0; exactly 64 SCLK rising edges.
- DIN_VLD held high continuously (burst undefined) → CS_N high for exactly 8 cycles between frames; accepts 529 cycles apart.
- RST_N pulsed low at SCLK edge 30 → CS_N=1, SCLK=0 asynchronously; no DOUT_VLD; next frame completes correctly.
- With SPI_MASTER_BURST_EN and two back-to-back words A5A5A5A5A5A5A5A5 and 5A5A5A5A5A5A5A5A → CS_N low continuously for 128 SCLK periods; two DOUT_VLD pulses.
- CLK_DIV=2, WORD_WIDTH=8, DIN=8'hC3 → SCLK period 4 cycles; CS_N low 36 cycles; MOSI 11000011.
